// File: rtl/usr_pkg.sv
// Shared types and constants for the usr serial frame receiver.
// Optional parity support is selected by the USR_RX_PARITY_EN macro in the consuming files.
package usr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam int unsigned USR_DEFAULT_WIDTH = 4;
  localparam logic        LINE_IDLE         = 1'b1;
  localparam logic        START_BIT         = 1'b0;

endpackage

// File: rtl/rx_shift_core.sv
// Direction-selectable deserialising shift register plus data-bit counter
// with a flag marking the last data bit of a frame.
module rx_shift_core
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = USR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             lsb_first,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic             last_bit
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign data     = shreg_q;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // LSB-first fills from the top so the first bit ends up in bit 0.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      if (lsb_first) begin
        shreg_d = {bit_in, shreg_q[WIDTH-1:1]};
      end else begin
        shreg_d = {shreg_q[WIDTH-2:0], bit_in};
      end
      cnt_d = last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/usr_frame_rx.sv
// Serial frame receiver: start/data/[parity]/stop FSM, frame checks and a one-entry
// valid/ready output register. Define USR_RX_PARITY_EN to add an even-parity bit.
module usr_frame_rx
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = USR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             lsb_first,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_data,
  output logic             out_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  rx_state_e        state_q, state_d;
  logic             lsb_first_q, lsb_first_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             overrun_q, overrun_d;
  logic             parity_bad;

  logic             sr_clear;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_data;
  logic             sr_last;

  rx_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (sr_clear),
    .shift_en (sr_shift),
    .lsb_first(lsb_first_q),
    .bit_in   (serial_in),
    .data     (sr_data),
    .last_bit (sr_last)
  );

`ifdef USR_RX_PARITY_EN
  logic parity_bit_q, parity_bit_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bit_q <= 1'b0;
    end else begin
      parity_bit_q <= parity_bit_d;
    end
  end

  assign parity_bad = (^sr_data) ^ parity_bit_q;
`else
  assign parity_bad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    lsb_first_d  = lsb_first_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q & ~out_ready;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    sr_clear     = 1'b0;
    sr_shift     = 1'b0;
`ifdef USR_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bit_valid && (serial_in == START_BIT)) begin
          state_d     = ST_DATA;
          lsb_first_d = lsb_first;
          sr_clear    = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_valid) begin
          sr_shift = 1'b1;
          if (sr_last) begin
`ifdef USR_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
      ST_PARITY: begin
`ifdef USR_RX_PARITY_EN
        if (bit_valid) begin
          parity_bit_d = serial_in;
          state_d      = ST_STOP;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        // Checks are prioritised: framing, then parity, then output occupancy.
        if (bit_valid) begin
          state_d = ST_IDLE;
          if (serial_in != LINE_IDLE) begin
            frame_err_d = 1'b1;
          end else if (parity_bad) begin
            parity_err_d = 1'b1;
          end else if (out_valid_q && !out_ready) begin
            overrun_d = 1'b1;
          end else begin
            out_data_d  = sr_data;
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lsb_first_q  <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lsb_first_q  <= lsb_first_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign parallel_data = out_data_q;
  assign out_valid     = out_valid_q;
  assign frame_err     = frame_err_q;
  assign parity_err    = parity_err_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_usr_frame_rx.sv
// Directed self-checking bench for usr_frame_rx with an expected-word queue.
// Parity cases are compiled only when USR_RX_PARITY_EN is defined.
module tb_usr_frame_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         serial_in;
  logic         bit_valid;
  logic         lsb_first;
  logic         out_ready;
  logic [W-1:0] parallel_data;
  logic         out_valid;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  usr_frame_rx #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .lsb_first    (lsb_first),
    .out_ready    (out_ready),
    .parallel_data(parallel_data),
    .out_valid    (out_valid),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bits[i] is the i-th data bit on the wire
  function automatic logic [W-1:0] model_word(input logic [W-1:0] bits, input logic lsb);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) begin
      if (lsb) w[i] = bits[i];
      else     w[W-1-i] = bits[i];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    repeat (gap) begin
      bit_valid = 1'b0;
      serial_in = 1'($urandom_range(0, 1));
      tick();
    end
    serial_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] bits, input logic lsb, input logic stop_b,
                            input logic par_flip, input int gap, input logic rdy_at_stop);
    lsb_first = lsb;
    strobe(1'b0, gap);
    lsb_first = ~lsb;
    for (int i = 0; i < W; i++) strobe(bits[i], gap);
`ifdef USR_RX_PARITY_EN
    strobe((^bits) ^ par_flip, gap);
`endif
    out_ready = rdy_at_stop;
    strobe(stop_b, gap);
    out_ready = 1'b0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk({tag, "_data"}, 32'(parallel_data), 32'(exp_q[0]));
  endtask

  task automatic check_pulses(input string tag, input logic fe, input logic pe, input logic ov);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
    chk({tag, "_parity_err"}, 32'(parity_err), 32'(pe));
    chk({tag, "_overrun"}, 32'(overrun), 32'(ov));
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_out(tag);
  endtask

  initial begin
    logic [W-1:0] rb;
    reset     = 1'b1;
    serial_in = 1'b1;
    bit_valid = 1'b0;
    lsb_first = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_data", 32'(parallel_data), 32'(0));
    check_out("reset");
    check_pulses("reset", 1'b0, 1'b0, 1'b0);

    // LSB-first and MSB-first decoding of the same wire bits
    send_frame(4'b1101, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    exp_q.push_back(model_word(4'b1101, 1'b1));
    check_out("lsb_first");
    check_pulses("lsb_first", 1'b0, 1'b0, 1'b0);
    accept("lsb_accept");

    send_frame(4'b1101, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    exp_q.push_back(model_word(4'b1101, 1'b0));
    check_out("msb_first");
    accept("msb_accept");

    // bad stop bit
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_pulses("stop_bad", 1'b1, 1'b0, 1'b0);
    check_out("stop_bad");
    tick();
    check_pulses("stop_bad_next", 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    exp_q.push_back(model_word(4'b0110, 1'b1));
    check_out("after_frame_err");
    accept("after_frame_err_acc");

`ifdef USR_RX_PARITY_EN
    send_frame(4'b0111, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    check_pulses("parity_bad", 1'b0, 1'b1, 1'b0);
    check_out("parity_bad");
    tick();
    check_pulses("parity_bad_next", 1'b0, 1'b0, 1'b0);
    send_frame(4'b0111, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    exp_q.push_back(model_word(4'b0111, 1'b1));
    check_out("parity_good");
    check_pulses("parity_good", 1'b0, 1'b0, 1'b0);
    accept("parity_good_acc");
`endif

    // overrun: second word dropped, first held
    send_frame(4'b0011, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    exp_q.push_back(model_word(4'b0011, 1'b1));
    send_frame(4'b1000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    check_pulses("overrun", 1'b0, 1'b0, 1'b1);
    check_out("overrun_held");
    tick();
    check_pulses("overrun_next", 1'b0, 1'b0, 1'b0);
    accept("overrun_acc");

    // load and accept on the same edge
    send_frame(4'b1110, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    exp_q.push_back(model_word(4'b1110, 1'b1));
    send_frame(4'b0001, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(model_word(4'b0001, 1'b1));
    check_out("b2b");
    check_pulses("b2b", 1'b0, 1'b0, 1'b0);
    accept("b2b_acc");

    // reset mid-frame drops the held word and the partial frame
    send_frame(4'b0101, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    exp_q.push_back(model_word(4'b0101, 1'b1));
    check_out("pre_reset");
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("midreset_data", 32'(parallel_data), 32'(0));
    check_out("midreset");
    check_pulses("midreset", 1'b0, 1'b0, 1'b0);

    send_frame(4'hA, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    exp_q.push_back(model_word(4'hA, 1'b1));
    check_out("gapped_A");
    check_pulses("gapped_A", 1'b0, 1'b0, 1'b0);
    accept("gapped_A_acc");

    for (int n = 0; n < 4; n++) begin
      rb = W'($urandom);
      send_frame(rb, n[0], 1'b1, 1'b0, n % 2, 1'b0);
      exp_q.push_back(model_word(rb, n[0]));
      check_out("rand");
      accept("rand_acc");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
